pmm_sequencer: RTL

// Host-side controller for the PMM pattern-matching core. It loads config words into PMM, issues the
// PMM reset op, then streams text bytes through PMM one simulation op per byte. It runs the PMM

---
 rtl/pmm_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pmm_sequencer.sv
// rtl/pmm_sequencer.sv - host-side sequencer: PMM config writes, PMM reset op, one simulate op per text byte
// Optional build macro: PMM_SEQ_STOP_ON_MATCH_EN (drain the rest of the stream after the first match)
module pmm_sequencer #(
  parameter int CNT_W   = 16,
  parameter int POS_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [13:0]      cfg_addr,
  input  logic [63:0]      cfg_wdata,
  output logic             cfg_ack,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             match_found,
  output logic [CNT_W-1:0] match_count,
  output logic [POS_W-1:0] first_match_pos,
  output logic [POS_W-1:0] byte_count,
  output logic [63:0]      pmm_data,
  output logic [15:0]      pmm_control,
  output logic             pmm_valid,
  input  logic             pmm_ready,
  input  logic             pmm_accepted
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CFG_REQ = 4'd1;
  localparam logic [3:0] S_CFG_REL = 4'd2;
  localparam logic [3:0] S_RST_REQ = 4'd3;
  localparam logic [3:0] S_RST_REL = 4'd4;
  localparam logic [3:0] S_FETCH   = 4'd5;
  localparam logic [3:0] S_SIM_REQ = 4'd6;
  localparam logic [3:0] S_SIM_REL = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd9;
`ifdef PMM_SEQ_STOP_ON_MATCH_EN
  localparam logic [3:0] S_DRAIN   = 4'd8;
`endif

  localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_MAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [3:0]       r_state;
  logic [TW-1:0]    r_tmo;
  logic [13:0]      r_cfg_addr;
  logic [63:0]      r_cfg_data;
  logic [7:0]       r_byte;
  logic             r_last;
  logic             r_acc;
  logic             r_cfg_ack;
  logic             r_error;
  logic             r_found;
  logic [CNT_W-1:0] r_mcnt;
  logic [POS_W-1:0] r_fpos;
  logic [POS_W-1:0] r_bcnt;

  logic w_req;
  logic w_rel;
  logic w_hs_wait;
  logic w_tmo;

  assign w_req     = (r_state == S_CFG_REQ) || (r_state == S_RST_REQ) || (r_state == S_SIM_REQ);
  assign w_rel     = (r_state == S_CFG_REL) || (r_state == S_RST_REL) || (r_state == S_SIM_REL);
  assign w_hs_wait = (w_req && !pmm_ready) || (w_rel && pmm_ready);
  // r_tmo counts cycles spent stalled in the current phase; it restarts at every phase change
  assign w_tmo     = (TIMEOUT != 0) && w_hs_wait && (r_tmo == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_acc      <= 1'b0;
      r_cfg_ack  <= 1'b0;
      r_error    <= 1'b0;
      r_found    <= 1'b0;
      r_mcnt     <= '0;
      r_fpos     <= '0;
      r_bcnt     <= '0;
    end else begin
      r_cfg_ack <= 1'b0;
      r_tmo     <= (w_hs_wait && !w_tmo) ? r_tmo + 1'b1 : '0;
      if (w_tmo) begin
        r_state <= S_IDLE;
        r_error <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_we) begin
              r_cfg_addr <= cfg_addr;
              r_cfg_data <= cfg_wdata;
              r_error    <= 1'b0;
              r_state    <= S_CFG_REQ;
            end else if (start) begin
              r_error <= 1'b0;
              r_found <= 1'b0;
              r_mcnt  <= '0;
              r_fpos  <= '0;
              r_bcnt  <= '0;
              r_state <= S_RST_REQ;
            end
          end
          S_CFG_REQ: if (pmm_ready) r_state <= S_CFG_REL;
          S_CFG_REL: begin
            if (!pmm_ready) begin
              r_cfg_ack <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          S_RST_REQ: if (pmm_ready) r_state <= S_RST_REL;
          S_RST_REL: if (!pmm_ready) r_state <= S_FETCH;
          S_FETCH: begin
            if (s_valid) begin
              r_byte  <= s_data;
              r_last  <= s_last;
              r_state <= S_SIM_REQ;
            end
          end
          S_SIM_REQ: begin
            if (pmm_ready) begin
              r_acc   <= pmm_accepted;
              r_state <= S_SIM_REL;
            end
          end
          S_SIM_REL: begin
            if (!pmm_ready) begin
              if (~&r_bcnt) r_bcnt <= r_bcnt + 1'b1;
              if (r_acc) begin
                if (~&r_mcnt) r_mcnt <= r_mcnt + 1'b1;
                if (!r_found) r_fpos <= r_bcnt;
                r_found <= 1'b1;
              end
`ifdef PMM_SEQ_STOP_ON_MATCH_EN
              if (r_acc && !r_last) r_state <= S_DRAIN;
              else                  r_state <= r_last ? S_DONE : S_FETCH;
`else
              r_state <= r_last ? S_DONE : S_FETCH;
`endif
            end
          end
`ifdef PMM_SEQ_STOP_ON_MATCH_EN
          S_DRAIN: if (s_valid && s_last) r_state <= S_DONE;
`endif
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Op fields derive from state so an async reset clears pmm_valid and the bus instantly
  always_comb begin
    pmm_control = '0;
    pmm_data    = '0;
    case (r_state)
      S_CFG_REQ, S_CFG_REL: begin
        pmm_control = {2'b01, r_cfg_addr};
        pmm_data    = r_cfg_data;
      end
      S_RST_REQ, S_RST_REL: pmm_control = 16'hC000;
      S_SIM_REQ, S_SIM_REL: begin
        pmm_control = 16'h8000;
        pmm_data    = {56'd0, r_byte};
      end
      default: ;
    endcase
  end

  assign pmm_valid       = w_req;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
`ifdef PMM_SEQ_STOP_ON_MATCH_EN
  assign s_ready         = (r_state == S_FETCH) || (r_state == S_DRAIN);
`else
  assign s_ready         = (r_state == S_FETCH);
`endif
  assign cfg_ack         = r_cfg_ack;
  assign error           = r_error;
  assign match_found     = r_found;
  assign match_count     = r_mcnt;
  assign first_match_pos = r_fpos;
  assign byte_count      = r_bcnt;

endmodule
